spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave (peripheral) end of the team's SPI link; pairs directly with spi_master on the same board.
- Receives serial bytes on mosi and transmits a user-loaded byte on miso while cs is low.
- Fixed mode 0 (CPOL=0, CPHA=0), MSB first.
- All SPI pins are oversampled in the system clock domain; clk must be at least 4x spi_clk.

Parameters:
- DATA_WIDTH, 8, bits per transfer word.
- SYNC_STAGES, 2, synchronizer flops on spi_clk, cs and mosi (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- spi_clk  input  1  serial clock from master, idle low
- cs  input  1  chip select from master, active low
- mosi  input  1  serial data from master
- miso  output  1  serial data to master
- data_wr  input  DATA_WIDTH  byte to transmit
- wr_load  input  1  one-clk strobe; captures data_wr into tx_buf
- tx_used  output  1  one-clk pulse when tx_buf is copied into the shifter
- data_rd  output  DATA_WIDTH  last complete received word
- rd_valid  output  1  one-clk pulse; data_rd was updated
- state  output  2  FSM state, for debug

Behaviour:
- Reset values (async): miso=0, tx_used=0, data_rd=0, rd_valid=0, state=IDLE, tx_buf=0, shifters=0, bit_cnt=0.
  - Synchronizers reset to cs=1, spi_clk=0, mosi=0.
- Synchronization and edges: cs_s, sclk_s and mosi_s are the SYNC_STAGES-flop synchronized inputs. Rising and falling edges of sclk_s are detected against a 1-flop delayed copy.
- FSM encoding: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3.
- IDLE:
  - miso=0, bit_cnt=0.
  - cs_s low goes to LOAD.
- LOAD (1 clk):
  - tx_shift <= tx_buf; tx_used pulses; miso <= tx_buf MSB.
  - Then go to SHIFT.
- SHIFT, rising sclk_s:
  - rx_shift <= {rx_shift[W-2:0], mosi_s}; bit_cnt++.
  - If bit_cnt was W-1: data_rd <= {rx_shift[W-2:0], mosi_s}, bit_cnt <= 0, go to DONE.
- SHIFT, falling sclk_s:
  - If the word is mid-transfer: tx_shift shifts left; miso <= next bit.
  - If this falling edge follows word completion: tx_shift <= tx_buf; tx_used pulses; miso <= tx_buf MSB. This gives back-to-back words with no gaps.
- DONE (1 clk):
  - rd_valid=1, then return to SHIFT.
  - Edges are still processed in DONE.
- rd_valid latency: asserted within SYNC_STAGES+2 clk after the W-th spi_clk rising edge at the pin.
- tx_buf:
  - Loaded on any clk with wr_load=1, in any state.
  - If wr_load coincides with the copy, the shifter gets the old tx_buf and the new value serves the next word.
  - If no new load arrives, tx_buf is retransmitted.
- cs_s rising in any non-IDLE state:
  - Go to IDLE next clk; bit_cnt cleared.
  - Partial word discarded: no rd_valid, data_rd unchanged.
  - Takes priority over a simultaneous sclk_s edge.
- cs edges only matter in IDLE or as an abort; cs must stay low for a whole transfer to complete.
- Reset mid-transfer: immediate return to reset values; tx_buf is cleared.

Optional Feature:
- Macro: SPI_SLAVE_MISO_TRISTATE_EN.
- Defined: miso is driven only while cs (raw pin) is low, and is 1'bz when cs is high. This allows multiple slaves on a shared miso line.
- Undefined: miso is always driven; 0 in IDLE and during reset.

Test Plan:
- Reset: assert reset during bit 4 of a transfer. Required: miso=0, rd_valid=0, data_rd=0, state=0 within the same clk; after release, state stays 0 while cs=1.
- Single byte: wr_load with data_wr=8'hAB, then the master sends 8'h5A with spi_clk=clk/8. Required: miso bits sampled on rising edges = 1,0,1,0,1,0,1,1; data_rd=8'h5A; exactly one rd_valid pulse; one tx_used pulse.
- Back-to-back: cs held low for 16 bits with mosi=8'hC3 then 8'h0F; wr_load 8'h3C after the first tx_used. Required: miso sends AB then 3C; rd_valid pulses twice with data_rd C3, then 0F.
- Retransmit: two bytes with no wr_load after the initial 8'hAB. Required: miso sends AB twice.
- Abort: cs raised after 5 spi_clk rising edges. Required: no rd_valid, data_rd holds its previous value, state returns to 0. The next full transfer of 8'h96 gives data_rd=8'h96.
- Feature: with SPI_SLAVE_MISO_TRISTATE_EN defined, miso=z while cs=1 and driven while cs=0. Without the macro, miso=0 while cs=1.

Source files
------------

// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: SPI pins plus the parallel user-side word interface.
`timescale 1ns/1ps
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  spi_clk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  wr_load;
  logic                  tx_used;
  logic [DATA_WIDTH-1:0] data_rd;
  logic                  rd_valid;
  logic [1:0]            state;

  modport slave (
    input  spi_clk, cs, mosi, data_wr, wr_load,
    output miso, tx_used, data_rd, rd_valid, state
  );

  modport master (
    output spi_clk, cs, mosi, data_wr, wr_load,
    input  miso, tx_used, data_rd, rd_valid, state
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, with all pins oversampled in the clk domain.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release miso (1'bz) while the raw cs pin is high.
`timescale 1ns/1ps
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  spi_slave_if.slave bus
);
  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  cs_sync, sclk_sync, mosi_sync;
  logic                    cs_s, sclk_s, mosi_s, sclk_d;
  logic                    sclk_rise, sclk_fall;
  logic [DATA_WIDTH-1:0]   tx_buf, tx_shift, data_rd_q;
  // The newest bit goes straight into data_rd, so only W-1 bits need holding.
  logic [DATA_WIDTH-2:0]   rx_shift;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    word_done, miso_q, tx_used_q, rd_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_buf     <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      data_rd_q  <= '0;
      bit_cnt    <= '0;
      word_done  <= 1'b0;
      miso_q     <= 1'b0;
      tx_used_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      tx_used_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      // NOTE: non-blocking update means a copy in this same cycle still reads the old tx_buf.
      if (bus.wr_load) tx_buf <= bus.data_wr;

      case (state_q)
        IDLE: begin
          miso_q    <= 1'b0;
          bit_cnt   <= '0;
          word_done <= 1'b0;
          if (!cs_s) state_q <= LOAD;
        end
        LOAD: begin
          if (cs_s) begin
            state_q <= IDLE;
            bit_cnt <= '0;
          end else begin
            tx_shift  <= tx_buf;
            tx_used_q <= 1'b1;
            miso_q    <= tx_buf[DATA_WIDTH-1];
            state_q   <= SHIFT;
          end
        end
        SHIFT, DONE: begin
          if (cs_s) begin
            state_q   <= IDLE;
            bit_cnt   <= '0;
            word_done <= 1'b0;
          end else begin
            if (state_q == DONE) state_q <= SHIFT;
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
              if (bit_cnt == LAST_BIT) begin
                data_rd_q  <= {rx_shift, mosi_s};
                bit_cnt    <= '0;
                word_done  <= 1'b1;
                rd_valid_q <= 1'b1;
                state_q    <= DONE;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else if (sclk_fall) begin
              // The falling edge after a finished word starts the next one without a gap.
              if (word_done) begin
                tx_shift  <= tx_buf;
                tx_used_q <= 1'b1;
                miso_q    <= tx_buf[DATA_WIDTH-1];
                word_done <= 1'b0;
              end else begin
                tx_shift <= tx_shift << 1;
                miso_q   <= tx_shift[DATA_WIDTH-2];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign bus.miso = bus.cs ? 1'bz : miso_q;
`else
  assign bus.miso = miso_q;
`endif

  assign bus.tx_used  = tx_used_q;
  assign bus.data_rd  = data_rd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed plus randomized bursts against a word-level model.
`timescale 1ns/1ps
module tb_spi_slave;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  int   used_cnt = 0;
  logic [7:0] rd_q[$];
  logic [7:0] model_buf;
  logic [7:0] last_rx;
  logic [7:0] mosi_words [4];
  logic [7:0] miso_words [4];

  spi_slave_if #(.DATA_WIDTH(8)) bus ();

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      rd_cnt++;
      rd_q.push_back(bus.data_rd);
    end
    if (bus.tx_used === 1'b1) used_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    bus.data_wr = v;
    bus.wr_load = 1'b1;
    @(negedge clk);
    bus.wr_load = 1'b0;
    model_buf = v;
  endtask

  // One mode-0 word at spi_clk = clk/8; the master samples miso as it raises spi_clk.
  task automatic spi_word(input logic [7:0] tx, input bit last, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = tx[i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], bus.miso};
      bus.spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_clk = 1'b0;
      if (last && i == 0) bus.cs = 1'b1;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      repeat (4) @(negedge clk);
      bus.spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic run_burst(input string name, input int n, input bit mid_load, input logic [7:0] mid_val);
    logic [7:0] exp_tx [4];
    logic [7:0] got;
    int rd0, used0;
    rd_q.delete();
    rd0   = rd_cnt;
    used0 = used_cnt;
    exp_tx[0] = model_buf;
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
    if (mid_load) begin
      for (int k = 0; k < 40 && used_cnt == used0; k++) @(negedge clk);
      check({name, " first tx_used"}, 32'(used_cnt - used0), 32'd1);
      load(mid_val);
      repeat (4) @(negedge clk);
    end
    for (int w = 1; w < n; w++) exp_tx[w] = model_buf;
    for (int w = 0; w < n; w++) spi_word(mosi_words[w], w == n - 1, miso_words[w]);
    repeat (10) @(negedge clk);
    check({name, " rd_valid count"}, 32'(rd_cnt - rd0), 32'(n));
    check({name, " tx_used count"}, 32'(used_cnt - used0), 32'(n));
    for (int w = 0; w < n; w++) begin
      check($sformatf("%s miso w%0d", name, w), {24'd0, miso_words[w]}, {24'd0, exp_tx[w]});
      got = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
      check($sformatf("%s data_rd w%0d", name, w), {24'd0, got}, {24'd0, mosi_words[w]});
    end
    check({name, " state idle"}, {30'd0, bus.state}, 32'd0);
    last_rx = mosi_words[n-1];
  endtask

  initial begin
    int n;
    bit mid;
    reset       = 1'b1;
    bus.spi_clk = 1'b0;
    bus.cs      = 1'b1;
    bus.mosi    = 1'b0;
    bus.data_wr = '0;
    bus.wr_load = 1'b0;
    model_buf   = '0;
    last_rx     = '0;
    repeat (3) @(negedge clk);
    check("reset state", {30'd0, bus.state}, 32'd0);
    check("reset miso", {31'd0, bus.miso}, 32'd0);
    check("reset data_rd", {24'd0, bus.data_rd}, 32'd0);
    check("reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("reset tx_used", {31'd0, bus.tx_used}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    load(8'hAB);
    mosi_words[0] = 8'h5A;
    run_burst("single", 1, 1'b0, 8'h00);

    mosi_words[0] = 8'hC3;
    mosi_words[1] = 8'h0F;
    run_burst("b2b", 2, 1'b1, 8'h3C);

    load(8'hAB);
    mosi_words[0] = 8'h12;
    mosi_words[1] = 8'hE7;
    run_burst("retx", 2, 1'b0, 8'h00);

    begin
      int rd0;
      rd0 = rd_cnt;
      @(negedge clk);
      bus.cs = 1'b0;
      repeat (8) @(negedge clk);
      spi_bits(8'hFF, 5);
      bus.cs = 1'b1;
      repeat (10) @(negedge clk);
      check("abort rd_valid count", 32'(rd_cnt - rd0), 32'd0);
      check("abort data_rd held", {24'd0, bus.data_rd}, {24'd0, last_rx});
      check("abort state idle", {30'd0, bus.state}, 32'd0);
    end
    mosi_words[0] = 8'h96;
    run_burst("after abort", 1, 1'b0, 8'h00);

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) load(8'($urandom));
      n   = int'($urandom_range(1, 3));
      mid = (n > 1) && ($urandom_range(0, 1) == 1);
      for (int w = 0; w < n; w++) mosi_words[w] = 8'($urandom);
      run_burst($sformatf("rand%0d", r), n, mid, 8'($urandom));
    end

    // Reset asserted in the middle of bit 4 of a transfer.
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(8'hA5, 3);
    bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    bus.spi_clk = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset miso", {31'd0, bus.miso}, 32'd0);
    check("midreset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("midreset data_rd", {24'd0, bus.data_rd}, 32'd0);
    check("midreset state", {30'd0, bus.state}, 32'd0);
    model_buf   = '0;
    bus.cs      = 1'b1;
    bus.spi_clk = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post reset state", {30'd0, bus.state}, 32'd0);
    mosi_words[0] = 8'h3E;
    run_burst("post reset", 1, 1'b0, 8'h00);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    check("miso released cs high", {31'd0, bus.miso}, {31'd0, 1'bz});
    load(8'h80);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
    check("miso driven cs low", {31'd0, bus.miso}, 32'd1);
    bus.cs = 1'b1;
    repeat (2) @(negedge clk);
    check("miso released again", {31'd0, bus.miso}, {31'd0, 1'bz});
`else
    load(8'h80);
    repeat (4) @(negedge clk);
    check("miso low cs high", {31'd0, bus.miso}, 32'd0);
    bus.cs = 1'b0;
    repeat (8) @(negedge clk);
    check("miso driven cs low", {31'd0, bus.miso}, 32'd1);
    bus.cs = 1'b1;
    repeat (6) @(negedge clk);
    check("miso low after cs", {31'd0, bus.miso}, 32'd0);
`endif
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
